fp_mul_issuer: RTL and testbench

Initiator-side front end for the single-precision multiplier core. Buffers operand pairs from an upstream valid/ready source and issues each pair to the multiplier with a one-cycle `ready` pulse. It then waits for `done`, captures `res`, and presents it downstream with a valid/ack handshake. Only one operation is outstanding at a time, so results are strictly in order, and a watchdog flags a core that never answers.

---
 rtl/fp_mul_issuer.sv | 120 ++++++++++++
 tb/tb_fp_mul_issuer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_issuer.sv
// fp_mul_issuer: FIFO-buffered, one-at-a-time issuer for the fp multiplier with result hold and watchdog.
// Optional FP_SPECIAL_BYPASS_EN answers NaN/inf/zero operand pairs locally without using the core.
module fp_mul_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic        mul_ready,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic [31:0] mul_res,
  input  logic        mul_done,
  output logic        out_valid,
  input  logic        out_ack,
  output logic [31:0] out_res,
  output logic        out_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state;
  logic [31:0] mem_a [FIFO_DEPTH];
  logic [31:0] mem_b [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic [TW-1:0] tcnt;
  logic push, pop, byp;
  logic [31:0] byp_res;
  assign push = in_valid && in_ready;
  assign pop = (state == IDLE) && (count != '0);
  assign count_n = count + CW'(push) - CW'(pop);
`ifdef FP_SPECIAL_BYPASS_EN
  logic [31:0] ha, hb;
  logic na, nb, ia, ib, za, zb, sg;
  assign ha = mem_a[rptr];
  assign hb = mem_b[rptr];
  assign na = (&ha[30:23]) && (|ha[22:0]);
  assign nb = (&hb[30:23]) && (|hb[22:0]);
  assign ia = (&ha[30:23]) && !(|ha[22:0]);
  assign ib = (&hb[30:23]) && !(|hb[22:0]);
  assign za = !(|ha[30:23]);
  assign zb = !(|hb[30:23]);
  assign sg = ha[31] ^ hb[31];
  assign byp = na || nb || ia || ib || za || zb;
  assign byp_res = (na || nb || (ia && zb) || (za && ib)) ? 32'h7FC00000 :
                   (ia || ib) ? {sg, 8'hFF, 23'h0} : {sg, 31'h0};
`else
  assign byp = 1'b0;
  assign byp_res = '0;
`endif
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wptr] <= in_op1;
      mem_b[wptr] <= in_op2;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      tcnt      <= '0;
      mul_ready <= 1'b0;
      mul_op1   <= '0;
      mul_op2   <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_err   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count     <= count_n;
      in_ready  <= count_n != CW'(FIFO_DEPTH);
      mul_ready <= 1'b0;
      case (state)
        IDLE:
          if (pop && byp) begin
            out_res   <= byp_res;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (pop) begin
            mul_op1   <= mem_a[rptr];
            mul_op2   <= mem_b[rptr];
            mul_ready <= 1'b1;
            state     <= ISSUE;
          end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT:
          if (mul_done) begin
            out_res   <= mul_res;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            out_res   <= 32'h7FC00000;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else tcnt <= tcnt + 1'b1;
        HOLD:
          if (out_ack) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_issuer.sv
// tb_fp_mul_issuer: directed bench for fp_mul_issuer with a latency-programmable multiplier model.
module tb_fp_mul_issuer;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic mul_ready, mul_done = 1'b0;
  logic [31:0] mul_op1, mul_op2, mul_res = '0;
  logic out_valid, out_ack = 1'b0, out_err;
  logic [31:0] out_res;
  int checks = 0, errors = 0;
  int model_lat = 1, cd = 0, pulses = 0, dones = 0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic [31:0] va [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] vb [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
  fp_mul_issuer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
    .mul_ready(mul_ready), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_res(mul_res), .mul_done(mul_done),
    .out_valid(out_valid), .out_ack(out_ack), .out_res(out_res), .out_err(out_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000) return b;
    if (a == 32'h40000000 && b == 32'h40200000) return 32'h40A00000;
    if (a == 32'h3FA00000 && b == 32'h3F800000) return 32'h3FA00000;
    if (a == 32'h42C86666 && b == 32'h80000000) return 32'h80000000;
    if (a == 32'hFF800000 && b == 32'h45185B75) return 32'hFF800000;
    return 32'hBAD0BAD0;
  endfunction
  // done rises model_lat cycles after the issue cycle, so latency 1 lands in the first WAIT cycle
  always @(negedge clk) begin
    mul_done = 1'b0;
    if (mul_ready === 1'b1) begin
      pulses++;
      cur_a = mul_op1;
      cur_b = mul_op2;
      cd = model_lat;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mul_done = 1'b1;
        mul_res = prod(cur_a, cur_b);
        dones++;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_op1 = a;
    in_op2 = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(out_valid), 1);
  endtask
  task automatic ack();
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask
  task automatic result(input string tag, input logic [31:0] r, input logic e);
    wait_valid({tag, "_valid"});
    chk({tag, "_res"}, out_res, r);
    chk({tag, "_err"}, 32'(out_err), 32'(e));
    ack();
  endtask
  initial begin
    int p0, d0, n, acc, seen;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mul_ready", 32'(mul_ready), 0);
    chk("rst_mul_op1", mul_op1, 0);
    chk("rst_mul_op2", mul_op2, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_err", 32'(out_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    model_lat = 10;
    p0 = pulses;
    push(32'h40000000, 32'h40200000);
    wait_valid("t1_valid");
    chk("t1_pulses", 32'(pulses - p0), 1);
    chk("t1_op1", cur_a, 32'h40000000);
    chk("t1_op2", cur_b, 32'h40200000);
    chk("t1_res", out_res, 32'h40A00000);
    chk("t1_err", 32'(out_err), 0);
    ack();
    chk("t1_valid_drop", 32'(out_valid), 0);
    model_lat = 1;
    p0 = pulses;
    push(32'h40000000, 32'h40200000);
    push(32'h3FA00000, 32'h3F800000);
    wait_valid("t2a_valid");
    repeat (5) @(negedge clk);
    chk("t2_hold_pulses", 32'(pulses - p0), 1);
    chk("t2_hold_valid", 32'(out_valid), 1);
    chk("t2a_res", out_res, 32'h40A00000);
    ack();
    result("t2b", 32'h3FA00000, 1'b0);
    chk("t2_pulses", 32'(pulses - p0), 2);
    model_lat = 2;
    p0 = pulses;
    push(32'h42C86666, 32'h80000000);
    result("t3a", 32'h80000000, 1'b0);
    push(32'hFF800000, 32'h45185B75);
    result("t3b", 32'hFF800000, 1'b0);
`ifdef FP_SPECIAL_BYPASS_EN
    chk("t3_pulses", 32'(pulses - p0), 0);
`else
    chk("t3_pulses", 32'(pulses - p0), 2);
`endif
    model_lat = TIMEOUT + 2;
    push(32'h3F800000, 32'h40000000);
    n = 0;
    while (!mul_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_issue", 32'(mul_ready), 1);
    d0 = dones;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_wait_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("t4_res", out_res, 32'h7FC00000);
    chk("t4_err", 32'(out_err), 1);
    repeat (3) @(negedge clk);
    chk("t4_late_done_seen", 32'(dones - d0), 1);
    chk("t4_late_res", out_res, 32'h7FC00000);
    chk("t4_late_err", 32'(out_err), 1);
    ack();
    model_lat = 3;
    push(32'h40000000, 32'h40200000);
    result("t4_next", 32'h40A00000, 1'b0);
    model_lat = 12;
    p0 = pulses;
    push(32'h3F800000, 32'h3F000000);
    n = 0;
    while (!mul_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      if (in_ready && acc < 5) begin
        in_valid = 1'b1;
        in_op1 = va[acc];
        in_op2 = vb[acc];
        @(negedge clk);
        acc++;
      end else begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    chk("t5_accepted", 32'(acc), 32'(FIFO_DEPTH));
    chk("t5_full_ready", 32'(in_ready), 0);
    result("t5_first", 32'h3F000000, 1'b0);
    push(va[4], vb[4]);
    for (int k = 0; k < 5; k++) result("t5_q", vb[k], 1'b0);
    chk("t5_pulses", 32'(pulses - p0), 6);
    model_lat = 4;
    push(32'h3F800000, 32'h40000000);
    push(32'h3F800000, 32'h40400000);
    push(32'h3F800000, 32'h40800000);
    chk("t6_in_wait", 32'(out_valid), 0);
    p0 = pulses;
    d0 = dones;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", 32'(in_ready), 0);
    chk("t6_mul_ready", 32'(mul_ready), 0);
    chk("t6_mul_op1", mul_op1, 0);
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_out_res", out_res, 0);
    chk("t6_out_err", 32'(out_err), 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("t6_done_arrived", 32'(dones - d0), 1);
    chk("t6_no_pulse", 32'(pulses - p0), 0);
    chk("t6_no_valid", 32'(seen), 0);
    chk("t6_ready", 32'(in_ready), 1);
    chk("t6_op_hold", mul_op1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
